// File: rtl/simple_pkg.sv
// Shared fetch/decode definitions: command encodings, HLT field values, fetch FSM states.
package simple_pkg;

  localparam logic [15:0] NOP_CMD   = 16'hC0E0;
  localparam logic [1:0]  HLT_CLASS = 2'b11;
  localparam logic [3:0]  HLT_FUNC  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    HIST_HOLD       = 2'd0,
    HIST_LOAD_INSTR = 2'd1,
    HIST_LOAD_NOP   = 2'd2
  } hist_ctrl_e;

  function automatic logic is_hlt(input logic [15:0] instr);
    return (instr[15:14] == HLT_CLASS) && (instr[7:4] == HLT_FUNC);
  endfunction

endpackage

// File: rtl/cmd_history.sv
// Three-deep command history plus the address of the command currently in decode.
module cmd_history
  import simple_pkg::*;
#(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  hist_ctrl_e          ctrl,
  input  logic [15:0]         instr,
  input  logic [PC_WIDTH-1:0] instr_pc,
  output logic [15:0]         cmd,
  output logic [15:0]         before_cmd,
  output logic [15:0]         two_before_cmd,
  output logic [PC_WIDTH-1:0] cmd_pc
);

  logic [15:0]         cmd_r;
  logic [15:0]         before_cmd_r;
  logic [15:0]         two_before_cmd_r;
  logic [PC_WIDTH-1:0] cmd_pc_r;

  // History shift register; a NOP insertion keeps cmd_pc at the last real instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_r            <= NOP_CMD;
      before_cmd_r     <= NOP_CMD;
      two_before_cmd_r <= NOP_CMD;
      cmd_pc_r         <= {PC_WIDTH{1'b0}};
    end else begin
      case (ctrl)
        HIST_LOAD_INSTR: begin
          cmd_r            <= instr;
          before_cmd_r     <= cmd_r;
          two_before_cmd_r <= before_cmd_r;
          cmd_pc_r         <= instr_pc;
        end
        HIST_LOAD_NOP: begin
          cmd_r            <= NOP_CMD;
          before_cmd_r     <= cmd_r;
          two_before_cmd_r <= before_cmd_r;
        end
        default: begin
          cmd_r            <= cmd_r;
          before_cmd_r     <= before_cmd_r;
          two_before_cmd_r <= two_before_cmd_r;
          cmd_pc_r         <= cmd_pc_r;
        end
      endcase
    end
  end

  assign cmd            = cmd_r;
  assign before_cmd     = before_cmd_r;
  assign two_before_cmd = two_before_cmd_r;
  assign cmd_pc         = cmd_pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, start/run/halt control and command history for decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import simple_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  input  logic                PC_load,
  input  logic [PC_WIDTH-1:0] pc_target,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_rdata,
  output logic [15:0]         COMMAND,
  output logic [15:0]         BeforeCOMMAND,
  output logic [15:0]         TwoBeforeCOMMAND,
  output logic [PC_WIDTH-1:0] cmd_pc,
  output logic                halted,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
);

  fetch_state_e        state_r;
  fetch_state_e        next_state_s;
  hist_ctrl_e          hist_ctrl_s;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pc_next_s;
  logic                halted_r;

  // State, PC and halt flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      pc_r     <= pc_next_s;
      halted_r <= (next_state_s == ST_HALT);
    end
  end

  // Next-state logic; a redirect suppresses HLT detection
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_RUN;
        else       next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!PC_load && !stall && is_hlt(imem_rdata)) next_state_s = ST_HALT;
        else                                          next_state_s = ST_RUN;
      end
      ST_HALT: begin
        if (start) next_state_s = ST_RUN;
        else       next_state_s = ST_HALT;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // PC update and history control
  always_comb begin
    pc_next_s   = pc_r;
    hist_ctrl_s = HIST_HOLD;
    case (state_r)
      ST_IDLE: begin
        hist_ctrl_s = HIST_LOAD_NOP;
      end
      ST_RUN: begin
        if (PC_load) begin
          pc_next_s   = pc_target;
          hist_ctrl_s = HIST_LOAD_NOP;
        end else if (stall) begin
          hist_ctrl_s = HIST_HOLD;
        end else begin
          pc_next_s   = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
          hist_ctrl_s = HIST_LOAD_INSTR;
        end
      end
      ST_HALT: begin
        hist_ctrl_s = HIST_LOAD_NOP;
        if (PC_load) pc_next_s = pc_target;
        else         pc_next_s = pc_r;
      end
      default: begin
        pc_next_s   = pc_r;
        hist_ctrl_s = HIST_LOAD_NOP;
      end
    endcase
  end

  cmd_history #(
    .PC_WIDTH(PC_WIDTH)
  ) u_cmd_history (
    .clk           (clk),
    .rst           (rst),
    .ctrl          (hist_ctrl_s),
    .instr         (imem_rdata),
    .instr_pc      (pc_r),
    .cmd           (COMMAND),
    .before_cmd    (BeforeCOMMAND),
    .two_before_cmd(TwoBeforeCOMMAND),
    .cmd_pc        (cmd_pc)
  );

  assign imem_addr = pc_r;
  assign halted    = halted_r;

`ifdef FETCH_PERF_CNT_EN
  logic        fetch_inc_s;
  logic        stall_inc_s;
  logic [31:0] fetch_cnt_r;
  logic [31:0] stall_cnt_r;

  assign fetch_inc_s = (hist_ctrl_s == HIST_LOAD_INSTR);
  assign stall_inc_s = (state_r == ST_RUN) && stall && !PC_load;

  // Saturating fetch and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (fetch_inc_s && (fetch_cnt_r != 32'hFFFF_FFFF)) fetch_cnt_r <= fetch_cnt_r + 32'd1;
      if (stall_inc_s && (stall_cnt_r != 32'hFFFF_FFFF)) stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_r;
  assign perf_stall_cnt = stall_cnt_r;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural asynchronous instruction memory.
module tb_fetch_unit;
  import simple_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        PC_load;
  logic [15:0] pc_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] COMMAND;
  logic [15:0] BeforeCOMMAND;
  logic [15:0] TwoBeforeCOMMAND;
  logic [15:0] cmd_pc;
  logic        halted;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  logic [15:0] mem [0:65535];
  int checks;
  int errors;

  fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stall           (stall),
    .PC_load         (PC_load),
    .pc_target       (pc_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .COMMAND         (COMMAND),
    .BeforeCOMMAND   (BeforeCOMMAND),
    .TwoBeforeCOMMAND(TwoBeforeCOMMAND),
    .cmd_pc          (cmd_pc),
    .halted          (halted),
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; PC_load = 1'b0; pc_target = 16'h0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (COMMAND !== NOP_CMD) begin errors++; $display("FAIL reset_cmd got %h exp %h", COMMAND, NOP_CMD); end
    checks++; if (BeforeCOMMAND !== NOP_CMD || TwoBeforeCOMMAND !== NOP_CMD) begin errors++; $display("FAIL reset_hist got %h %h exp %h", BeforeCOMMAND, TwoBeforeCOMMAND, NOP_CMD); end
    checks++; if (cmd_pc !== 16'h0000 || imem_addr !== 16'h0000 || halted !== 1'b0) begin errors++; $display("FAIL reset_pc got cmd_pc %h addr %h halted %b", cmd_pc, imem_addr, halted); end
    checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d %0d exp 0 0", perf_fetch_cnt, perf_stall_cnt); end
    tick();
    checks++; if (imem_addr !== 16'h0000 || COMMAND !== NOP_CMD) begin errors++; $display("FAIL idle_hold got addr %h cmd %h", imem_addr, COMMAND); end
  endtask

  task automatic test_fetch();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (imem_addr !== 16'h0000 || COMMAND !== NOP_CMD) begin errors++; $display("FAIL fetch_c1 got addr %h cmd %h", imem_addr, COMMAND); end
    tick();
    checks++; if (COMMAND !== 16'h8101 || BeforeCOMMAND !== NOP_CMD || cmd_pc !== 16'h0000) begin errors++; $display("FAIL fetch_c2 got %h %h pc %h exp 8101 %h 0000", COMMAND, BeforeCOMMAND, cmd_pc, NOP_CMD); end
    tick();
    checks++; if (COMMAND !== 16'h8202 || BeforeCOMMAND !== 16'h8101 || TwoBeforeCOMMAND !== NOP_CMD) begin errors++; $display("FAIL fetch_c3 got %h %h %h", COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND); end
    tick();
    checks++; if (COMMAND !== 16'hC010 || BeforeCOMMAND !== 16'h8202 || TwoBeforeCOMMAND !== 16'h8101 || cmd_pc !== 16'h0002 || imem_addr !== 16'h0003) begin errors++; $display("FAIL fetch_c4 got %h %h %h pc %h addr %h", COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND, cmd_pc, imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL fetch_halted got %b exp 0", halted); end
  endtask

  task automatic test_redirect();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (imem_addr !== 16'h0005 || COMMAND !== 16'h1004) begin errors++; $display("FAIL redir_pre got addr %h cmd %h exp 0005 1004", imem_addr, COMMAND); end
    PC_load = 1'b1; pc_target = 16'h0040; tick(); PC_load = 1'b0;
    checks++; if (COMMAND !== NOP_CMD || BeforeCOMMAND !== 16'h1004 || imem_addr !== 16'h0040) begin errors++; $display("FAIL redir_bubble got %h %h addr %h", COMMAND, BeforeCOMMAND, imem_addr); end
    tick();
    checks++; if (COMMAND !== 16'h8440 || cmd_pc !== 16'h0040 || BeforeCOMMAND !== NOP_CMD) begin errors++; $display("FAIL redir_target got %h pc %h before %h exp 8440 0040", COMMAND, cmd_pc, BeforeCOMMAND); end
  endtask

  task automatic test_stall();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (imem_addr !== 16'h0003 || COMMAND !== 16'hC010 || BeforeCOMMAND !== 16'h8202 || TwoBeforeCOMMAND !== 16'h8101 || cmd_pc !== 16'h0002) begin errors++; $display("FAIL stall_hold%0d got addr %h %h %h %h pc %h", i, imem_addr, COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND, cmd_pc); end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_stall_cnt !== 32'd3 || perf_fetch_cnt !== 32'd3) begin errors++; $display("FAIL stall_perf got %0d %0d exp 3 3", perf_stall_cnt, perf_fetch_cnt); end
`else
    checks++; if (perf_stall_cnt !== 32'd0 || perf_fetch_cnt !== 32'd0) begin errors++; $display("FAIL stall_perf_off got %0d %0d exp 0 0", perf_stall_cnt, perf_fetch_cnt); end
`endif
    stall = 1'b0; tick();
    checks++; if (COMMAND !== 16'h1003 || cmd_pc !== 16'h0003 || imem_addr !== 16'h0004) begin errors++; $display("FAIL stall_resume got %h pc %h addr %h", COMMAND, cmd_pc, imem_addr); end
    stall = 1'b1; PC_load = 1'b1; pc_target = 16'h0100; tick(); PC_load = 1'b0;
    checks++; if (COMMAND !== NOP_CMD || BeforeCOMMAND !== 16'h1003 || imem_addr !== 16'h0100) begin errors++; $display("FAIL stall_redir got %h %h addr %h", COMMAND, BeforeCOMMAND, imem_addr); end
    tick(); stall = 1'b0;
    checks++; if (COMMAND !== NOP_CMD || imem_addr !== 16'h0100) begin errors++; $display("FAIL stall_after_redir got %h addr %h", COMMAND, imem_addr); end
  endtask

  task automatic test_halt();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (imem_addr !== 16'h0007 || halted !== 1'b0) begin errors++; $display("FAIL halt_pre got addr %h halted %b", imem_addr, halted); end
    tick();
    checks++; if (COMMAND !== 16'hC0F0 || halted !== 1'b1 || imem_addr !== 16'h0008 || BeforeCOMMAND !== 16'h1006) begin errors++; $display("FAIL halt_latch got %h halted %b addr %h before %h", COMMAND, halted, imem_addr, BeforeCOMMAND); end
    stall = 1'b1; tick();
    checks++; if (COMMAND !== NOP_CMD || BeforeCOMMAND !== 16'hC0F0 || TwoBeforeCOMMAND !== 16'h1006) begin errors++; $display("FAIL halt_drain1 got %h %h %h", COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND); end
    tick(); tick(); stall = 1'b0;
    checks++; if (COMMAND !== NOP_CMD || BeforeCOMMAND !== NOP_CMD || TwoBeforeCOMMAND !== NOP_CMD || imem_addr !== 16'h0008 || halted !== 1'b1) begin errors++; $display("FAIL halt_drained got %h %h %h addr %h halted %b", COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND, imem_addr, halted); end
    start = 1'b1; tick(); start = 1'b0;
    checks++; if (halted !== 1'b0 || imem_addr !== 16'h0008 || COMMAND !== NOP_CMD) begin errors++; $display("FAIL halt_restart got halted %b addr %h cmd %h", halted, imem_addr, COMMAND); end
    tick();
    checks++; if (COMMAND !== 16'h1008 || cmd_pc !== 16'h0008 || imem_addr !== 16'h0009) begin errors++; $display("FAIL halt_resume got %h pc %h addr %h exp 1008 0008 0009", COMMAND, cmd_pc, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_fetch_cnt !== 32'd9 || perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL halt_perf got %0d %0d exp 9 0", perf_fetch_cnt, perf_stall_cnt); end
`endif
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    PC_load = 1'b1; pc_target = 16'hFFFF; tick(); PC_load = 1'b0;
    checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_load got addr %h exp ffff", imem_addr); end
    tick();
    checks++; if (imem_addr !== 16'h0000 || COMMAND !== 16'h1FFF || cmd_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap got addr %h cmd %h pc %h exp 0000 1fff ffff", imem_addr, COMMAND, cmd_pc); end
    tick();
    rst = 1'b1; start = 1'b1; PC_load = 1'b1; pc_target = 16'h0123; tick();
    rst = 1'b0; start = 1'b0; PC_load = 1'b0;
    checks++; if (COMMAND !== NOP_CMD || BeforeCOMMAND !== NOP_CMD || TwoBeforeCOMMAND !== NOP_CMD || cmd_pc !== 16'h0000 || imem_addr !== 16'h0000 || halted !== 1'b0) begin errors++; $display("FAIL midrun_reset got %h %h %h pc %h addr %h halted %b", COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND, cmd_pc, imem_addr, halted); end
    checks++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL midrun_reset_perf got %0d %0d", perf_fetch_cnt, perf_stall_cnt); end
    tick();
    checks++; if (imem_addr !== 16'h0000 || COMMAND !== NOP_CMD) begin errors++; $display("FAIL post_reset_idle got addr %h cmd %h", imem_addr, COMMAND); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h1000 | (a & 16'h0FFF);
    mem[0]     = 16'h8101;
    mem[1]     = 16'h8202;
    mem[2]     = 16'hC010;
    mem[7]     = 16'hC0F0;
    mem[16'h40] = 16'h8440;
    rst = 1'b1; start = 1'b0; stall = 1'b0; PC_load = 1'b0; pc_target = 16'h0000;
    test_reset();
    test_fetch();
    test_redirect();
    test_stall();
    test_halt();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decode unit. Holds the program counter, reads 16-bit instructions from an asynchronous-read instruction memory, and drives the three-deep command history (`COMMAND`, `BeforeCOMMAND`, `TwoBeforeCOMMAND`) that decode uses for forwarding detection. Handles PC redirect on taken branches, stalls, a start/halt state machine, and squashing with a decode-neutral NOP.

## Interface
- `PC_WIDTH`, 16: program counter and instruction-memory address width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: leave IDLE or HALT and begin fetching.
- `stall`  in  1: hold PC and the whole command history this cycle.
- `PC_load`  in  1: taken branch/jump from execute; redirect PC.
- `pc_target`  in  PC_WIDTH: redirect address, valid when `PC_load`=1.
- `imem_addr`  out  PC_WIDTH: instruction-memory address (equals PC register).
- `imem_rdata`  in  16: instruction at `imem_addr`, same-cycle (asynchronous) read.
- `COMMAND`  out  16: instruction currently presented to decode.
- `BeforeCOMMAND`  out  16: previous `COMMAND`.
- `TwoBeforeCOMMAND`  out  16: `COMMAND` from two advances ago.
- `cmd_pc`  out  PC_WIDTH: address of the instruction in `COMMAND`.
- `halted`  out  1: high in HALT state.
- `perf_fetch_cnt`  out  32: instructions accepted into `COMMAND` (see Configuration).
- `perf_stall_cnt`  out  32: cycles in RUN with `stall`=1 (see Configuration).

## Operation
- NOP_CMD = 16'hC0E0 (class 11, function 1110): decodes to no register, memory, flag or PC write and never matches a forwarding source.
- HLT: `imem_rdata[15:14]`=11 and `[7:4]`=1111.
- States: IDLE, RUN, HALT.
- Reset: state IDLE; PC=`RESET_PC`; all three command registers = NOP_CMD; `cmd_pc`=0; `halted`=0; counters=0.
- IDLE: `start`=1 moves to RUN next cycle; otherwise history shifts NOP_CMD in; PC holds.
- RUN advance (no stall, no redirect): `COMMAND`<=`imem_rdata`, `cmd_pc`<=PC, `BeforeCOMMAND`<=`COMMAND`, `TwoBeforeCOMMAND`<=`BeforeCOMMAND`, PC<=PC+1 modulo 2^PC_WIDTH (0xFFFF wraps to 0x0000).
- RUN, `PC_load`=1: PC<=`pc_target`; `COMMAND`<=NOP_CMD (wrong-path fetch squashed); history still shifts. `PC_load` overrides `stall` and HLT detection.
- RUN, `stall`=1, `PC_load`=0: PC, all three command registers and `cmd_pc` hold.
- RUN, HLT fetched (no stall, no redirect): HLT latched into `COMMAND`, PC<=PC+1, state→HALT.
- HALT: `halted`=1; PC holds; history shifts NOP_CMD in each cycle so the pipeline drains; `stall` ignored. `start`=1 returns to RUN, resuming at PC (instruction after HLT). `PC_load` in HALT loads PC, stays HALT.
- `start` in RUN ignored.

## Timing
- Fetch-to-decode latency: 1 cycle (address in cycle n, `COMMAND` valid in n+1).
- Redirect penalty: 1 bubble; target instruction in `COMMAND` two cycles after `PC_load` cycle.
- IDLE/HALT→RUN: first real instruction in `COMMAND` two cycles after `start` sampled.
- `halted` rises the cycle after HLT appears in `COMMAND`... precisely: on the same edge HLT is latched into `COMMAND`.
- Reset mid-operation: all state returns to reset values on the next edge regardless of `stall`, `PC_load`, `start`.

## Configuration
- `FETCH_PERF_CNT_EN` defined: `perf_fetch_cnt` increments on each RUN advance loading `imem_rdata` (not on squash/NOP insertion); `perf_stall_cnt` increments each RUN cycle with `stall`=1 and `PC_load`=0; both saturate at 0xFFFFFFFF, cleared by reset.
- Not defined: counter logic absent; both ports tied to 0.

## Structure
- Shared package `simple_pkg`: NOP_CMD, HLT class/function field constants, fetch state enum (IDLE/RUN/HALT).
- One sub-module `cmd_history`: three 16-bit registers plus `cmd_pc`, with controls hold / load-instruction / load-NOP; reset to NOP_CMD.

## Test plan
- Reset then `start`, imem[0..2]=16'h8101,16'h8202,16'hC010 → `COMMAND` sequence 8101,8202,C010 on cycles 2,3,4 after start; `BeforeCOMMAND` lags by one, `TwoBeforeCOMMAND` by two.
- `PC_load`=1, `pc_target`=16'h0040 while PC=5 → next `COMMAND`=NOP_CMD, then imem[0x40] with `cmd_pc`=0x0040.
- `stall`=1 for 3 cycles mid-stream → PC and all command outputs frozen; with macro `perf_stall_cnt`=3.
- `stall`=1 and `PC_load`=1 same cycle → redirect taken, `COMMAND`=NOP_CMD.
- HLT (16'hC0F0) at address 7 → `halted`=1, history drains to NOP_CMD after 3 cycles, PC=8; `start` resumes fetch at 8.
- PC at 16'hFFFF advancing → next PC 16'h0000; `rst` asserted mid-run → all outputs at reset values next cycle, state IDLE.
